// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : forwarding, load-use, branch flush and mul/div     |
// | sequencing for a 5-stage RISC-V pipeline. Optional: HAZARD_PERF_CNT_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 32,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  LoadE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MdStartE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MdBusy,
    output logic [PERF_W-1:0]     StallCnt,
    output logic [PERF_W-1:0]     FlushCnt
);

    localparam logic [0:0] c_idle      = 1'b0;
    localparam logic [0:0] c_busy      = 1'b1;
    localparam logic [7:0] c_md_reload = 8'(MD_LATENCY - 2);

    logic [0:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       guard_q, guard_d;
    logic       w_md;
    logic       w_lw;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end

    assign w_lw = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // The guard blocks an immediate re-issue of the op that just finished
    assign w_md = ((state_q == c_idle) && MdStartE && !guard_q) || (state_q == c_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_idle;
            cnt_q   <= 8'd0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        guard_d = 1'b0;
        case (state_q)
            c_idle: begin
                if (MdStartE && !guard_q) begin
                    state_d = c_busy;
                    cnt_d   = c_md_reload;
                end
            end
            c_busy: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = c_idle;
                    guard_d = 1'b1;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (w_md) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            FlushD = PCSrcE;
            FlushE = PCSrcE | w_lw;
            StallF = w_lw & ~PCSrcE;
            StallD = w_lw & ~PCSrcE;
        end
        MdBusy = w_md;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1))            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if ((FlushD || FlushE) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
`default_nettype wire
